dualshock_responder: RTL and testbench

Device-side (responder) end of the DualShock/PS2 controller serial link: it answers host polls exactly as a physical pad does. It sits behind the Pmod pad connector so the board can act as a controller for an external host, and it serves as the bench model for the host-side `dualshock_controller`. It oversamples the host's SEL/CLK/CMD lines in the system clock domain, shifts out the reply LSB-first, pulses ACK after each byte and captures the host's vibration bytes.

---
 rtl/dualshock_responder.sv | 194 +++++++++++++++++++
 tb/tb_dualshock_responder.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/dualshock_responder.sv
// dualshock_responder: device end of the DualShock/PS2 pad link, answering host polls like a physical pad.
// Define DS_ANALOG_EN for analog mode (ID 0x73, 9-byte reply carrying the stick bytes).
module dualshock_responder #(
    parameter int ACK_DELAY = 50,
    parameter int ACK_WIDTH = 50
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ps_sel_n,
    input  logic        ps_clk,
    input  logic        ps_cmd,
    output logic        ps_dat,
    output logic        ps_ack_n,
    input  logic [15:0] btn,
    input  logic [31:0] stick,
    output logic [7:0]  vib_small,
    output logic [7:0]  vib_large,
    output logic        poll_done,
    output logic        frame_err
);
`ifdef DS_ANALOG_EN
    localparam logic [7:0] ID = 8'h73;
    localparam logic [3:0] LAST = 4'd8;
`else
    localparam logic [7:0] ID = 8'h41;
    localparam logic [3:0] LAST = 4'd4;
    logic unused_stick;
    assign unused_stick = ^stick;
`endif
    localparam int CW = $clog2((ACK_DELAY > ACK_WIDTH ? ACK_DELAY : ACK_WIDTH) + 1);
    localparam logic [2:0] IDLE = 3'd0, SHIFT = 3'd1, ACK_WAIT = 3'd2, ACK_PULSE = 3'd3, DONE = 3'd4;

    // {cmd, clk, sel}; left unreset so a reset mid-frame cannot fabricate a SEL edge
    logic [2:0] s1_q, s2_q, s3_q, s4_q;
    always_ff @(posedge clk) begin
        s1_q <= {ps_cmd, ps_clk, ps_sel_n};
        s2_q <= s1_q;
        s3_q <= s2_q;
        s4_q <= s3_q;
    end
    logic sel_fall, sel_hi, clk_fall, clk_rise, cmd;
    assign sel_fall = s4_q[0] & ~s3_q[0];
    assign sel_hi   = s3_q[0];
    assign clk_fall = s4_q[1] & ~s3_q[1];
    assign clk_rise = ~s4_q[1] & s3_q[1];
    assign cmd      = s3_q[2];

    logic [2:0]    state_q, state_d, bit_q, bit_d;
    logic [3:0]    byte_q, byte_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [6:0]    rx_q, rx_d;
    logic [15:0]   btn_q, btn_d;
    logic [31:0]   stick_q, stick_d;
    logic [7:0]    vs_q, vs_d, vl_q, vl_d, vib_s_q, vib_s_d, vib_l_q, vib_l_d, reply, host_byte;
    logic          dat_q, dat_d, ok_q, ok_d, pd_q, pd_d, fe_q, fe_d;

    always_comb begin
        reply = 8'hFF;
        case (byte_q)
            4'd1: reply = ID;
            4'd2: reply = 8'h5A;
            4'd3: reply = btn_q[7:0];
            4'd4: reply = btn_q[15:8];
`ifdef DS_ANALOG_EN
            4'd5: reply = stick_q[7:0];
            4'd6: reply = stick_q[15:8];
            4'd7: reply = stick_q[23:16];
            4'd8: reply = stick_q[31:24];
`endif
            default: reply = 8'hFF;
        endcase
    end

    always_comb begin
        state_d = state_q;
        bit_d = bit_q;
        byte_d = byte_q;
        cnt_d = cnt_q;
        rx_d = rx_q;
        dat_d = dat_q;
        btn_d = btn_q;
        stick_d = stick_q;
        vs_d = vs_q;
        vl_d = vl_q;
        vib_s_d = vib_s_q;
        vib_l_d = vib_l_q;
        ok_d = ok_q;
        pd_d = 1'b0;
        fe_d = 1'b0;
        host_byte = {cmd, rx_q};
        case (state_q)
            IDLE: if (sel_fall) begin
                btn_d = btn;
`ifdef DS_ANALOG_EN
                stick_d = stick;
`endif
                bit_d = 3'd0;
                byte_d = 4'd0;
                ok_d = 1'b0;
                dat_d = 1'b1; // byte 0 is 0xFF, so a coincident CLK fall drives 1 as well
                state_d = SHIFT;
            end
            SHIFT: if (sel_hi) begin
                fe_d = 1'b1;
                state_d = IDLE;
            end else if (clk_fall) begin
                dat_d = reply[bit_q];
            end else if (clk_rise) begin
                rx_d = {cmd, rx_q[6:1]};
                bit_d = bit_q + 3'd1;
                if (bit_q == 3'd7) begin
                    cnt_d = '0;
                    if ((byte_q == 4'd0 && host_byte != 8'h01) || (byte_q == 4'd1 && host_byte != 8'h42)) begin
                        fe_d = 1'b1;
                        state_d = DONE;
                    end else begin
                        vs_d = (byte_q == 4'd3) ? host_byte : vs_q;
                        vl_d = (byte_q == 4'd4) ? host_byte : vl_q;
                        ok_d = (byte_q == LAST);
                        state_d = (byte_q == LAST) ? DONE : ACK_WAIT;
                    end
                end
            end
            ACK_WAIT: if (sel_hi) begin
                fe_d = 1'b1;
                state_d = IDLE;
            end else begin
                cnt_d = (cnt_q == CW'(ACK_DELAY - 1)) ? '0 : cnt_q + 1'b1;
                state_d = (cnt_q == CW'(ACK_DELAY - 1)) ? ACK_PULSE : ACK_WAIT;
            end
            ACK_PULSE: if (sel_hi) begin
                fe_d = 1'b1;
                state_d = IDLE;
            end else if (cnt_q == CW'(ACK_WIDTH - 1)) begin
                byte_d = byte_q + 4'd1;
                bit_d = 3'd0;
                dat_d = 1'b1;
                state_d = SHIFT;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            DONE: if (sel_hi) begin
                vib_s_d = ok_q ? vs_q : vib_s_q;
                vib_l_d = ok_q ? vl_q : vib_l_q;
                pd_d = ok_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            bit_q <= '0;
            byte_q <= '0;
            cnt_q <= '0;
            rx_q <= '0;
            dat_q <= 1'b1;
            btn_q <= '1;
            stick_q <= '0;
            vs_q <= '0;
            vl_q <= '0;
            vib_s_q <= '0;
            vib_l_q <= '0;
            ok_q <= 1'b0;
            pd_q <= 1'b0;
            fe_q <= 1'b0;
        end else begin
            state_q <= state_d;
            bit_q <= bit_d;
            byte_q <= byte_d;
            cnt_q <= cnt_d;
            rx_q <= rx_d;
            dat_q <= dat_d;
            btn_q <= btn_d;
            stick_q <= stick_d;
            vs_q <= vs_d;
            vl_q <= vl_d;
            vib_s_q <= vib_s_d;
            vib_l_q <= vib_l_d;
            ok_q <= ok_d;
            pd_q <= pd_d;
            fe_q <= fe_d;
        end
    end

    assign ps_dat    = (state_q == SHIFT) ? dat_q : 1'b1;
    assign ps_ack_n  = (state_q != ACK_PULSE);
    assign vib_small = vib_s_q;
    assign vib_large = vib_l_q;
    assign poll_done = pd_q;
    assign frame_err = fe_q;
endmodule

// File: tb/tb_dualshock_responder.sv
// tb_dualshock_responder: directed host polls against dualshock_responder with hand-computed replies.
module tb_dualshock_responder;
    localparam int AD = 6;
    localparam int AW = 5;
    localparam int H = 8;
`ifdef DS_ANALOG_EN
    localparam int N = 9;
    localparam logic [71:0] EXP1 = 72'h80_7F_10_F0_FE_FB_5A_73_FF;
`else
    localparam int N = 5;
    localparam logic [71:0] EXP1 = 72'hFF_FF_FF_FF_FE_FB_5A_41_FF;
`endif
    localparam logic [71:0] CMD1 = 72'h00_00_00_00_80_FF_00_42_01;

    logic clk = 1'b0, reset, ps_sel_n, ps_clk, ps_cmd, ps_dat, ps_ack_n, poll_done, frame_err;
    logic [15:0] btn;
    logic [31:0] stick;
    logic [7:0] vib_small, vib_large;
    int n_vec = 0, n_err = 0, pd_cnt = 0, fe_cnt = 0;

    dualshock_responder #(.ACK_DELAY(AD), .ACK_WIDTH(AW)) dut (
        .clk(clk), .reset(reset), .ps_sel_n(ps_sel_n), .ps_clk(ps_clk), .ps_cmd(ps_cmd),
        .ps_dat(ps_dat), .ps_ack_n(ps_ack_n), .btn(btn), .stick(stick),
        .vib_small(vib_small), .vib_large(vib_large), .poll_done(poll_done), .frame_err(frame_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) begin
        if (poll_done) pd_cnt <= pd_cnt + 1;
        if (frame_err) fe_cnt <= fe_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic host_byte(input logic [7:0] c, input int nbits, output logic [7:0] r);
        r = 8'hFF;
        for (int i = 0; i < nbits; i++) begin
            ps_clk = 1'b0;
            ps_cmd = c[i];
            cycles(H);
            r[i] = ps_dat;
            ps_clk = 1'b1;
            if (i != 7) cycles(H);
        end
    endtask

    task automatic ack_check(input bit exp, input string tag);
        int k, w;
        k = 0;
        while (ps_ack_n && k < AD + 12) begin
            cycles(1);
            k++;
        end
        if (exp) begin
            check({tag, "_delay"}, k, AD + 4);
            w = 0;
            while (!ps_ack_n && w < AW + 12) begin
                cycles(1);
                w++;
            end
            check({tag, "_width"}, w, AW);
        end else begin
            check({tag, "_none"}, k, AD + 12);
        end
        cycles(H);
    endtask

    task automatic poll(input logic [71:0] cmds, input int nack, output logic [71:0] rsp);
        logic [7:0] rb;
        rsp = '1;
        ps_sel_n = 1'b0;
        cycles(H);
        for (int b = 0; b < N; b++) begin
            host_byte(cmds[8*b +: 8], 8, rb);
            rsp[8*b +: 8] = rb;
            ack_check(b < nack, $sformatf("ack%0d", b));
        end
        ps_sel_n = 1'b1;
        cycles(8);
    endtask

    logic [71:0] rsp;
    logic [7:0] rb;
    int pd0, fe0, k;

    initial begin
        reset = 1'b1;
        ps_sel_n = 1'b1;
        ps_clk = 1'b1;
        ps_cmd = 1'b1;
        btn = 16'hFEFB;
        stick = 32'h807F10F0;
        cycles(6);
        reset = 1'b0;
        cycles(2);
        check("rst_dat", ps_dat, 1);
        check("rst_ack", ps_ack_n, 1);
        check("rst_vib", {vib_large, vib_small}, 16'h0000);
        check("rst_pulses", pd_cnt + fe_cnt, 0);

        // full valid poll
        pd0 = pd_cnt; fe0 = fe_cnt;
        poll(CMD1, N - 1, rsp);
        for (int b = 0; b < N; b++) check($sformatf("poll1_rsp%0d", b), rsp[8*b +: 8], EXP1[8*b +: 8]);
        check("poll1_done", pd_cnt - pd0, 1);
        check("poll1_err", fe_cnt - fe0, 0);
        check("poll1_vib", {vib_large, vib_small}, 16'h80FF);

        // bad header byte 0
        pd0 = pd_cnt; fe0 = fe_cnt;
        poll(72'h00_00_00_00_11_22_00_42_81, 0, rsp);
        for (int b = 0; b < N; b++) check($sformatf("bad_rsp%0d", b), rsp[8*b +: 8], 8'hFF);
        check("bad_err", fe_cnt - fe0, 1);
        check("bad_done", pd_cnt - pd0, 0);
        check("bad_vib", {vib_large, vib_small}, 16'h80FF);

        // SEL released 3 bits into byte 2
        pd0 = pd_cnt; fe0 = fe_cnt;
        ps_sel_n = 1'b0;
        cycles(H);
        host_byte(8'h01, 8, rb);
        ack_check(1, "abt_ack0");
        host_byte(8'h42, 8, rb);
        check("abt_id", rb, EXP1[15:8]);
        ack_check(1, "abt_ack1");
        host_byte(8'h00, 3, rb);
        check("abt_dat_before", ps_dat, 0);
        ps_sel_n = 1'b1;
        cycles(4);
        check("abt_dat", ps_dat, 1);
        check("abt_ackn", ps_ack_n, 1);
        cycles(8);
        check("abt_err", fe_cnt - fe0, 1);
        check("abt_done", pd_cnt - pd0, 0);
        check("abt_vib", {vib_large, vib_small}, 16'h80FF);
        pd0 = pd_cnt;
        poll(72'h00_00_00_00_34_12_00_42_01, N - 1, rsp);
        check("after_abt_done", pd_cnt - pd0, 1);
        check("after_abt_vib", {vib_large, vib_small}, 16'h3412);

        // btn changes mid-frame must not affect the snapshot
        btn = 16'hFFFF;
        fork
            poll(CMD1, N - 1, rsp);
            begin
                cycles(20);
                btn = 16'h0000;
            end
        join
        check("snap_btn", rsp[39:24], 16'hFFFF);
        poll(CMD1, N - 1, rsp);
        check("snap_next", rsp[39:24], 16'h0000);

        // reset during ACK_PULSE
        pd0 = pd_cnt; fe0 = fe_cnt;
        ps_sel_n = 1'b0;
        cycles(H);
        host_byte(8'h01, 8, rb);
        k = 0;
        while (ps_ack_n && k < AD + 12) begin
            cycles(1);
            k++;
        end
        check("rstmid_ack_seen", ps_ack_n, 0);
        cycles(1);
        reset = 1'b1;
        cycles(1);
        check("rstmid_ackn", ps_ack_n, 1);
        check("rstmid_dat", ps_dat, 1);
        check("rstmid_vib", {vib_large, vib_small}, 16'h0000);
        reset = 1'b0;
        cycles(4);
        ps_sel_n = 1'b1;
        ps_clk = 1'b1;
        cycles(12);
        check("rstmid_pulses", (pd_cnt - pd0) + (fe_cnt - fe0), 0);
        btn = 16'hFEFB;
        poll(CMD1, N - 1, rsp);
        for (int b = 0; b < N; b++) check($sformatf("final_rsp%0d", b), rsp[8*b +: 8], EXP1[8*b +: 8]);
        check("final_done", pd_cnt - pd0, 1);
        check("final_vib", {vib_large, vib_small}, 16'h80FF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
